exu_wb_arbiter: RTL and testbench
=================================

EXU_WB_ARBITER -- requirements
Module: exu_wb_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk in 1 system clock; rst in 1 async reset, active-high.
REQ-002 SHALL have the ALU result port: alu_we_i in 1 write request; alu_waddr_i in 5 dest reg; alu_wdata_i in 32 result; alu_ready_o out 1 buffer can accept.
REQ-003 SHALL have the mul/div port: muldiv_valid_i in 1; muldiv_waddr_i in 5; muldiv_wdata_i in 32; muldiv_ready_o out 1.
REQ-004 SHALL have the control inputs: flush_i in 1 discard buffered ALU results.
REQ-005 SHALL have the regfile write port: reg_we_o out 1; reg_waddr_o out 5; reg_wdata_o out 32.
REQ-006 SHALL have the forwarding port: fwd_raddr_i in 5; fwd_hit_o out 1; fwd_data_o out 32.
REQ-007 SHALL have the status output: busy_o out 1, high while FIFO non-empty.

Function
REQ-010 SHALL buffer ALU results in a 2-entry FIFO (rd_ptr, wr_ptr, 2-bit count 0..2); pointers wrap 1->0.
REQ-011 SHALL enqueue at clk edge when alu_we_i=1, alu_ready_o=1, flush_i=0, alu_waddr_i!=0; waddr 0 is silently dropped.
REQ-012 SHALL drive alu_ready_o = (count!=2), combinational from count only.
REQ-013 SHALL drive muldiv_ready_o = (count!=2); transfer when muldiv_valid_i & muldiv_ready_o.
REQ-014 SHALL arbitrate per cycle: muldiv transfer wins over FIFO head; when count==2 muldiv_ready_o=0 so FIFO head wins (starvation guard).
REQ-015 SHALL drive reg_* combinationally from the winner: muldiv transfer -> reg_we_o=(muldiv_waddr_i!=0), muldiv addr/data; else count!=0 -> reg_we_o=1, head addr/data, head dequeues at edge; else reg_we_o=0, addr/data 0.
REQ-016 ALU latency: accepted at edge ending cycle N, earliest reg_we_o high in cycle N+1; muldiv latency 0.
REQ-017 Simultaneous enqueue and dequeue SHALL keep count unchanged; order strictly FIFO.
REQ-018 flush_i=1 SHALL clear count and pointers at next edge, block enqueue that cycle, and suppress FIFO-head write that cycle; muldiv transfer unaffected.
REQ-019 busy_o SHALL equal (count!=0).

Reset
REQ-020 While rst=1: count=0, rd_ptr=wr_ptr=0, entries' valid cleared; outputs reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0, alu_ready_o=1, muldiv_ready_o=1 (unless muldiv), busy_o=0, fwd_hit_o=0, fwd_data_o=0.
REQ-021 Reset mid-operation SHALL discard all buffered results; no write issued for them after release.
REQ-022 Entry data registers need not be reset; only pointers/count.

Configuration
REQ-030 Macro WB_FWD_EN SHALL compile in forwarding: fwd_hit_o=1 when fwd_raddr_i!=0 matches any valid FIFO entry; fwd_data_o = data of youngest matching entry; else both 0.
REQ-031 Without WB_FWD_EN, ports SHALL remain present, fwd_hit_o=0, fwd_data_o=0, fwd_raddr_i unused; all other behaviour identical.

Verification
REQ-040 Single ALU: cycle0 alu_we_i=1, waddr=5, wdata=0x1234; no muldiv -> cycle1 reg_we_o=1, reg_waddr_o=5, reg_wdata_o=0x1234; cycle2 reg_we_o=0, busy_o=0.
REQ-041 Conflict: ALU x3<-0xA accepted cycle0; cycle1 muldiv_valid_i=1 x7<-0xB -> cycle1 writes x7/0xB, cycle2 writes x3/0xA.
REQ-042 Full: hold muldiv_valid_i=1 continuously, ALU issues x1,x2,x3 -> count reaches 2, alu_ready_o=0 and muldiv_ready_o=0, head x1 written, then x2, x3 in order, no loss.
REQ-043 Zero reg: alu_we_i=1 waddr=0 -> no enqueue, reg_we_o stays 0; muldiv waddr=0 -> ready handshake completes, reg_we_o=0.
REQ-044 Flush/reset: two entries buffered, muldiv holding port; flush_i=1 (or rst=1) -> next cycle count=0, busy_o=0, buffered results never written.
REQ-045 With WB_FWD_EN: buffer x4<-0x11 then x4<-0x22, fwd_raddr_i=4 -> fwd_hit_o=1, fwd_data_o=0x22; fwd_raddr_i=0 -> fwd_hit_o=0.

Source files
------------

// File: rtl/exu_wb_arbiter.sv
// Writeback arbiter: merges a 2-entry buffered ALU result stream with a zero-latency mul/div port.
// Define WB_FWD_EN to compile in forwarding from buffered ALU results.
module exu_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_we_i,
  input  logic [4:0]  alu_waddr_i,
  input  logic [31:0] alu_wdata_i,
  output logic        alu_ready_o,
  input  logic        muldiv_valid_i,
  input  logic [4:0]  muldiv_waddr_i,
  input  logic [31:0] muldiv_wdata_i,
  output logic        muldiv_ready_o,
  input  logic        flush_i,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  input  logic [4:0]  fwd_raddr_i,
  output logic        fwd_hit_o,
  output logic [31:0] fwd_data_o,
  output logic        busy_o
);

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } entry_t;

  entry_t         entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic           wr_ptr_q, wr_ptr_d;
  logic [1:0]     count_q, count_d;

  logic not_full;
  logic md_xfer;
  logic enq;
  logic deq;

  assign not_full       = (count_q != 2'd2);
  assign alu_ready_o    = not_full;
  assign muldiv_ready_o = not_full;
  assign busy_o         = (count_q != 2'd0);
  assign md_xfer        = muldiv_valid_i & not_full;
  assign enq            = alu_we_i & not_full & ~flush_i & (alu_waddr_i != AW'(0));
  // Head only drains when mul/div is idle; a full FIFO forces mul/div off the port.
  assign deq            = ~md_xfer & busy_o & ~flush_i;

  // Writeback port selection
  always_comb begin
    reg_we_o    = 1'b0;
    reg_waddr_o = '0;
    reg_wdata_o = '0;
    if (md_xfer) begin
      reg_we_o    = (muldiv_waddr_i != AW'(0));
      reg_waddr_o = muldiv_waddr_i;
      reg_wdata_o = muldiv_wdata_i;
    end else if (deq) begin
      reg_we_o    = 1'b1;
      reg_waddr_o = entry_q[rd_ptr_q].waddr;
      reg_wdata_o = entry_q[rd_ptr_q].wdata;
    end
  end

  // FIFO bookkeeping next state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    valid_d  = valid_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      valid_d  = '0;
      count_d  = 2'd0;
    end else begin
      if (deq) begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = ~rd_ptr_q;
      end
      if (enq) begin
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d          = ~wr_ptr_q;
      end
      count_d = count_q + 2'(enq) - 2'(deq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      valid_q  <= '0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; validity lives in valid_q
  always_ff @(posedge clk) begin
    if (enq) begin
      entry_q[wr_ptr_q] <= '{waddr: alu_waddr_i, wdata: alu_wdata_i};
    end
  end

`ifdef WB_FWD_EN
  logic young_idx;
  logic young_hit;
  logic old_hit;

  // The most recently written slot sits just behind wr_ptr
  assign young_idx = ~wr_ptr_q;
  assign young_hit = valid_q[young_idx] && (entry_q[young_idx].waddr == fwd_raddr_i);
  assign old_hit   = valid_q[wr_ptr_q] && (entry_q[wr_ptr_q].waddr == fwd_raddr_i);

  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    if (fwd_raddr_i != AW'(0)) begin
      if (young_hit) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = entry_q[young_idx].wdata;
      end else if (old_hit) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = entry_q[wr_ptr_q].wdata;
      end
    end
  end
`else
  logic unused_fwd_raddr;

  assign unused_fwd_raddr = ^fwd_raddr_i;
  assign fwd_hit_o        = 1'b0;
  assign fwd_data_o       = '0;
`endif

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Directed bench for exu_wb_arbiter: inputs change #1 after posedge, outputs sampled at negedge.
module tb_exu_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_we_i;
  logic [4:0]  alu_waddr_i;
  logic [31:0] alu_wdata_i;
  logic        alu_ready_o;
  logic        muldiv_valid_i;
  logic [4:0]  muldiv_waddr_i;
  logic [31:0] muldiv_wdata_i;
  logic        muldiv_ready_o;
  logic        flush_i;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic [4:0]  fwd_raddr_i;
  logic        fwd_hit_o;
  logic [31:0] fwd_data_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exu_wb_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .alu_we_i       (alu_we_i),
    .alu_waddr_i    (alu_waddr_i),
    .alu_wdata_i    (alu_wdata_i),
    .alu_ready_o    (alu_ready_o),
    .muldiv_valid_i (muldiv_valid_i),
    .muldiv_waddr_i (muldiv_waddr_i),
    .muldiv_wdata_i (muldiv_wdata_i),
    .muldiv_ready_o (muldiv_ready_o),
    .flush_i        (flush_i),
    .reg_we_o       (reg_we_o),
    .reg_waddr_o    (reg_waddr_o),
    .reg_wdata_o    (reg_wdata_o),
    .fwd_raddr_i    (fwd_raddr_i),
    .fwd_hit_o      (fwd_hit_o),
    .fwd_data_o     (fwd_data_o),
    .busy_o         (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Set ALU and mul/div inputs for the coming cycle
  task automatic drive(input logic awe, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    alu_we_i       = awe;
    alu_waddr_i    = aa;
    alu_wdata_i    = ad;
    muldiv_valid_i = mv;
    muldiv_waddr_i = ma;
    muldiv_wdata_i = md;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_we"}, 32'(reg_we_o), 32'(we));
    if (we) begin
      check({tag, "_addr"}, 32'(reg_waddr_o), 32'(a));
      check({tag, "_data"}, reg_wdata_o, d);
    end
  endtask

  initial begin
    rst         = 1'b1;
    flush_i     = 1'b0;
    fwd_raddr_i = 5'd0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    sample();
    check("rst_we",     32'(reg_we_o), 32'd0);
    check("rst_waddr",  32'(reg_waddr_o), 32'd0);
    check("rst_wdata",  reg_wdata_o, 32'd0);
    check("rst_aready", 32'(alu_ready_o), 32'd1);
    check("rst_mready", 32'(muldiv_ready_o), 32'd1);
    check("rst_busy",   32'(busy_o), 32'd0);
    check("rst_fhit",   32'(fwd_hit_o), 32'd0);
    check("rst_fdata",  fwd_data_o, 32'd0);
    rst = 1'b0;
    next_cycle();

    // Single ALU result appears one cycle after acceptance
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
    sample();
    chk_wb("s_c0", 1'b0, 5'd0, 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    sample();
    chk_wb("s_c1", 1'b1, 5'd5, 32'h1234);
    check("s_c1_busy", 32'(busy_o), 32'd1);
    next_cycle();
    sample();
    chk_wb("s_c2", 1'b0, 5'd0, 32'h0);
    check("s_c2_busy", 32'(busy_o), 32'd0);
    next_cycle();

    // Mul/div beats the buffered ALU result
    drive(1'b1, 5'd3, 32'hA, 1'b0, 5'd0, 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hB);
    sample();
    chk_wb("c_c1", 1'b1, 5'd7, 32'hB);
    check("c_c1_busy", 32'(busy_o), 32'd1);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    sample();
    chk_wb("c_c2", 1'b1, 5'd3, 32'hA);
    next_cycle();
    sample();
    check("c_c3_busy", 32'(busy_o), 32'd0);
    next_cycle();

    // Full FIFO: mul/div held valid, ALU x1,x2,x3 drain in order
    drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd9, 32'h99);
    sample();
    chk_wb("f_c0", 1'b1, 5'd9, 32'h99);
    next_cycle();
    drive(1'b1, 5'd2, 32'h102, 1'b1, 5'd9, 32'h99);
    sample();
    chk_wb("f_c1", 1'b1, 5'd9, 32'h99);
    next_cycle();
    drive(1'b1, 5'd3, 32'h103, 1'b1, 5'd9, 32'h99);
    sample();
    check("f_c2_aready", 32'(alu_ready_o), 32'd0);
    check("f_c2_mready", 32'(muldiv_ready_o), 32'd0);
    chk_wb("f_c2", 1'b1, 5'd1, 32'h101);
    next_cycle();
    sample();
    check("f_c3_aready", 32'(alu_ready_o), 32'd1);
    chk_wb("f_c3", 1'b1, 5'd9, 32'h99);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    sample();
    check("f_c4_mready", 32'(muldiv_ready_o), 32'd0);
    chk_wb("f_c4", 1'b1, 5'd2, 32'h102);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    sample();
    chk_wb("f_c5", 1'b1, 5'd3, 32'h103);
    next_cycle();
    sample();
    chk_wb("f_c6", 1'b0, 5'd0, 32'h0);
    check("f_c6_busy", 32'(busy_o), 32'd0);
    next_cycle();

    // Register zero is never written
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBEEF);
    sample();
    check("z_busy",   32'(busy_o), 32'd0);
    check("z_mready", 32'(muldiv_ready_o), 32'd1);
    check("z_we",     32'(reg_we_o), 32'd0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    sample();
    check("z_we2", 32'(reg_we_o), 32'd0);
    next_cycle();

    // Fill two entries behind mul/div, then forwarding and flush
    drive(1'b1, 5'd4, 32'h11, 1'b1, 5'd9, 32'h99);
    next_cycle();
    drive(1'b1, 5'd4, 32'h22, 1'b1, 5'd9, 32'h99);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    fwd_raddr_i = 5'd4;
    flush_i     = 1'b1;
    sample();
    check("fl_busy_pre", 32'(busy_o), 32'd1);
    check("fl_we_supp",  32'(reg_we_o), 32'd0);
`ifdef WB_FWD_EN
    check("fwd_hit",  32'(fwd_hit_o), 32'd1);
    check("fwd_data", fwd_data_o, 32'h22);
    fwd_raddr_i = 5'd0;
    #1;
    check("fwd_r0_hit", 32'(fwd_hit_o), 32'd0);
`else
    check("fwd_off_hit",  32'(fwd_hit_o), 32'd0);
    check("fwd_off_data", fwd_data_o, 32'd0);
`endif
    next_cycle();
    flush_i     = 1'b0;
    fwd_raddr_i = 5'd0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    sample();
    check("fl_busy", 32'(busy_o), 32'd0);
    check("fl_we",   32'(reg_we_o), 32'd0);
    next_cycle();
    sample();
    check("fl_we2", 32'(reg_we_o), 32'd0);
    next_cycle();

    // Flush with one entry does not block a mul/div transfer
    drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h88);
    flush_i = 1'b1;
    sample();
    chk_wb("flm", 1'b1, 5'd8, 32'h88);
    next_cycle();
    flush_i = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    sample();
    check("flm_busy", 32'(busy_o), 32'd0);
    check("flm_we",   32'(reg_we_o), 32'd0);
    next_cycle();

    // Reset mid-operation discards both entries
    drive(1'b1, 5'd10, 32'hA0, 1'b1, 5'd9, 32'h99);
    next_cycle();
    drive(1'b1, 5'd11, 32'hB0, 1'b1, 5'd9, 32'h99);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    sample();
    check("r_full", 32'(alu_ready_o), 32'd0);
    rst = 1'b1;
    #1;
    check("r_busy",  32'(busy_o), 32'd0);
    check("r_we",    32'(reg_we_o), 32'd0);
    check("r_ready", 32'(alu_ready_o), 32'd1);
    next_cycle();
    rst = 1'b0;
    sample();
    check("r_we2", 32'(reg_we_o), 32'd0);
    next_cycle();
    sample();
    check("r_we3",   32'(reg_we_o), 32'd0);
    check("r_busy3", 32'(busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
